copy_emit_stage: RTL and testbench

Clocked packet stage directly downstream of the copy/exchange control stage in the data-driven pipeline. It accepts one token packet over a 4-phase Send/Ack handshake and latches it with its CPY/EXB mode bits. It re-emits the packet downstream once, or twice in copy mode, optionally swapping left/right operands. It is the synchronous boundary between the self-timed ring and clocked matching/execution logic.

---
 rtl/copy_emit_stage.sv | 150 +++++++++++++++
 tb/tb_copy_emit_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/copy_emit_stage.sv
// rtl/copy_emit_stage.sv - clocked copy/exchange emit stage between the self-timed ring and clocked logic (optional CX_PKT_CNT_EN)
module copy_emit_stage #(
    parameter int  DATA_W = 16,
    parameter int  TAG_W  = 8,
    localparam int PKT_W  = TAG_W + 2 * DATA_W
) (
    input  logic             CLK,
    input  logic             MR_n,
    input  logic             Send_in,
    output logic             Ack_out,
    input  logic [PKT_W-1:0] Pkt_in,
    input  logic             CPY,
    input  logic             EXB,
    output logic             Send_out,
    input  logic             Ack_in,
    output logic [PKT_W-1:0] Pkt_out,
    output logic             Copy_idx,
`ifdef CX_PKT_CNT_EN
    output logic [15:0]      Pkt_cnt,
`endif
    output logic             Busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RTZ  = 2'd2
    } state_t;

    state_t           state_r, state_nxt;
    logic             send_r, send_nxt;
    logic             busy_r, busy_nxt;
    logic             idx_r, idx_nxt;
    logic             ack_r;
    logic             accept;
    logic [PKT_W-1:0] pkt_r;
    logic             cpy_r;
    logic             exb_r;

    // Output handshake state register; every output-side flag moves with the state
    always_ff @(posedge CLK) begin
        if (!MR_n) begin
            state_r <= IDLE;
            send_r  <= 1'b0;
            busy_r  <= 1'b0;
            idx_r   <= 1'b0;
        end else begin
            state_r <= state_nxt;
            send_r  <= send_nxt;
            busy_r  <= busy_nxt;
            idx_r   <= idx_nxt;
        end
    end

    // Next-state logic: one REQ/RTZ round per emission, a second round in copy mode
    always_comb begin
        accept    = Send_in && !busy_r && !ack_r;
        state_nxt = state_r;
        send_nxt  = send_r;
        busy_nxt  = busy_r;
        idx_nxt   = idx_r;
        case (state_r)
            IDLE: begin
                if (accept) begin
                    state_nxt = REQ;
                    send_nxt  = 1'b1;
                    busy_nxt  = 1'b1;
                    idx_nxt   = 1'b0;
                end
            end
            REQ: begin
                if (Ack_in) begin
                    state_nxt = RTZ;
                    send_nxt  = 1'b0;
                end
            end
            RTZ: begin
                if (!Ack_in) begin
                    if (cpy_r && !idx_r) begin
                        state_nxt = REQ;
                        send_nxt  = 1'b1;
                        idx_nxt   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        idx_nxt   = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                send_nxt  = 1'b0;
                busy_nxt  = 1'b0;
                idx_nxt   = 1'b0;
            end
        endcase
    end

    // Input side: latch packet and mode bits on accept; ack stays up until Send_in is seen low
    always_ff @(posedge CLK) begin
        if (!MR_n) begin
            ack_r <= 1'b0;
            pkt_r <= '0;
            cpy_r <= 1'b0;
            exb_r <= 1'b0;
        end else begin
            if (accept) begin
                ack_r <= 1'b1;
                pkt_r <= Pkt_in;
                cpy_r <= CPY;
                exb_r <= EXB;
            end else if (!Send_in) begin
                ack_r <= 1'b0;
            end
        end
    end

    // Emitted packet: operands optionally swapped, forced to zero while the buffer is empty
    always_comb begin
        Pkt_out = '0;
        if (busy_r) begin
            if (exb_r) begin
                Pkt_out = {pkt_r[PKT_W-1 -: TAG_W], pkt_r[DATA_W-1:0], pkt_r[2*DATA_W-1 -: DATA_W]};
            end else begin
                Pkt_out = pkt_r;
            end
        end
    end

`ifdef CX_PKT_CNT_EN
    logic [15:0] cnt_r;

    // Completed output handshakes: every RTZ exit counts, wrapping naturally at 16 bits
    always_ff @(posedge CLK) begin
        if (!MR_n) begin
            cnt_r <= '0;
        end else if (state_r == RTZ && !Ack_in) begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

    assign Pkt_cnt = cnt_r;
`endif

    assign Ack_out  = ack_r;
    assign Send_out = send_r;
    assign Busy     = busy_r;
    assign Copy_idx = idx_r;

endmodule

// File: tb/tb_copy_emit_stage.sv
// tb/tb_copy_emit_stage.sv - scoreboard testbench for copy_emit_stage
module tb_copy_emit_stage;

    logic        CLK = 1'b0;
    logic        MR_n;
    logic        Send_in;
    logic        Ack_out;
    logic [39:0] Pkt_in;
    logic        CPY;
    logic        EXB;
    logic        Send_out;
    logic        Ack_in;
    logic [39:0] Pkt_out;
    logic        Copy_idx;
    logic        Busy;
`ifdef CX_PKT_CNT_EN
    logic [15:0] Pkt_cnt;
`endif

    copy_emit_stage dut (
        .CLK      (CLK),
        .MR_n     (MR_n),
        .Send_in  (Send_in),
        .Ack_out  (Ack_out),
        .Pkt_in   (Pkt_in),
        .CPY      (CPY),
        .EXB      (EXB),
        .Send_out (Send_out),
        .Ack_in   (Ack_in),
        .Pkt_out  (Pkt_out),
        .Copy_idx (Copy_idx),
`ifdef CX_PKT_CNT_EN
        .Pkt_cnt  (Pkt_cnt),
`endif
        .Busy     (Busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [39:0] pkt;
        logic        idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   emissions = 0;
    logic prev_send = 1'b0;
    logic [39:0] held_pkt = '0;

    logic resp_en   = 1'b0;
    logic resp_hold = 1'b0;
    int   max_dly   = 0;
    int   rdly      = 0;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout", name);
    endtask

    // Reference: an accepted packet yields one emission, two if copying; exchange swaps operands
    task automatic push_exp(input logic [39:0] pkt, input logic cpy, input logic exb);
        exp_t e;
        e.pkt = exb ? {pkt[39:32], pkt[15:0], pkt[31:16]} : pkt;
        e.idx = 1'b0;
        exp_q.push_back(e);
        if (cpy) begin
            e.idx = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: compare each new emission, then stability while held, and zero output when empty
    always @(negedge CLK) begin
        if (MR_n === 1'b1) begin
            if (Send_out && !prev_send) begin
                emissions++;
                held_pkt = Pkt_out;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_emission actual=%h expected=none", Pkt_out);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("emit_pkt", Pkt_out, e.pkt);
                    check("emit_idx", {39'd0, Copy_idx}, {39'd0, e.idx});
                end
            end else if (Send_out) begin
                check("pkt_stable", Pkt_out, held_pkt);
            end
            if (!Busy) check("pkt_zero_idle", Pkt_out, 40'd0);
        end
        prev_send = Send_out;
    end

    // Downstream partner: random-latency 4-phase acknowledge, optional hold high on copy emission
    always @(negedge CLK) begin
        if (MR_n !== 1'b1) begin
            Ack_in = 1'b0;
            rdly   = 0;
        end else if (resp_en) begin
            if (!Ack_in && Send_out) begin
                if (rdly == 0) begin
                    Ack_in = 1'b1;
                    rdly   = $urandom_range(0, max_dly);
                end else rdly--;
            end else if (Ack_in && !Send_out && !(resp_hold && Copy_idx)) begin
                if (rdly == 0) begin
                    Ack_in = 1'b0;
                    rdly   = $urandom_range(0, max_dly);
                end else rdly--;
            end
        end
    end

    task automatic wait_ack_out(input logic val, input string name);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (Ack_out !== val && n < 300);
        if (Ack_out !== val) timeout(name);
    endtask

    task automatic send_pkt(input logic [39:0] pkt, input logic cpy, input logic exb);
        @(negedge CLK);
        push_exp(pkt, cpy, exb);
        Send_in = 1'b1;
        Pkt_in  = pkt;
        CPY     = cpy;
        EXB     = exb;
        wait_ack_out(1'b1, "upstream_ack_rise");
        Send_in = 1'b0;
        Pkt_in  = {$urandom, $urandom};
        CPY     = 1'($urandom);
        EXB     = 1'($urandom);
        wait_ack_out(1'b0, "upstream_ack_fall");
    endtask

    // Wait for both handshakes to settle, then compare the handshake counter if present
    task automatic quiesce(input string name);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while ((Busy || Send_out || Ack_in || Ack_out) && n < 500);
        if (Busy || Send_out || Ack_in || Ack_out) timeout(name);
`ifdef CX_PKT_CNT_EN
        check("pkt_cnt", {24'd0, Pkt_cnt}, 40'(emissions[15:0]));
`endif
    endtask

    initial begin
        int e0;
        int n;
        MR_n    = 1'b0;
        Send_in = 1'b0;
        Pkt_in  = '0;
        CPY     = 1'b0;
        EXB     = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_send_out", {39'd0, Send_out}, 40'd0);
        check("rst_ack_out", {39'd0, Ack_out}, 40'd0);
        check("rst_busy", {39'd0, Busy}, 40'd0);
        check("rst_pkt_out", Pkt_out, 40'd0);
        check("rst_copy_idx", {39'd0, Copy_idx}, 40'd0);
        MR_n    = 1'b1;
        resp_en = 1'b1;
        max_dly = 0;
        @(negedge CLK);

        // Single packet with one-cycle latency check
        e0 = emissions;
        push_exp(40'hA5_1234_5678, 1'b0, 1'b0);
        Send_in = 1'b1;
        Pkt_in  = 40'hA5_1234_5678;
        CPY     = 1'b0;
        EXB     = 1'b0;
        @(negedge CLK);
        check("lat_send_out", {39'd0, Send_out}, 40'd1);
        check("lat_ack_out", {39'd0, Ack_out}, 40'd1);
        check("lat_busy", {39'd0, Busy}, 40'd1);
        Send_in = 1'b0;
        quiesce("single_quiesce");
        check("single_count", 40'(emissions - e0), 40'd1);

        // Exchange
        send_pkt(40'h3C_00FF_AA55, 1'b0, 1'b1);
        quiesce("exb_quiesce");

        // Copy: two emissions
        e0 = emissions;
        send_pkt(40'h11_0001_0002, 1'b1, 1'b0);
        quiesce("copy_quiesce");
        check("copy_count", 40'(emissions - e0), 40'd2);

        // Backpressure and no bypass on the input side
        resp_en = 1'b0;
        send_pkt(40'h5A_BEEF_CAFE, 1'b0, 1'b0);
        @(negedge CLK);
        push_exp(40'h77_1111_2222, 1'b0, 1'b1);
        Send_in = 1'b1;
        Pkt_in  = 40'h77_1111_2222;
        EXB     = 1'b1;
        CPY     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("bp_send_held", {39'd0, Send_out}, 40'd1);
            check("bp_no_ack", {39'd0, Ack_out}, 40'd0);
        end
        resp_en = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (Busy && n < 100);
        if (Busy) timeout("bp_busy_fall");
        check("bp_no_bypass", {39'd0, Ack_out}, 40'd0);
        @(negedge CLK);
        check("bp_accept_next", {39'd0, Ack_out}, 40'd1);
        Send_in = 1'b0;
        quiesce("bp_quiesce");

        // Reset while in RTZ of the copy emission
        resp_hold = 1'b1;
        send_pkt(40'h42_0A0A_0B0B, 1'b1, 1'b0);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(Copy_idx && !Send_out && Busy && Ack_in) && n < 100);
        if (!(Copy_idx && !Send_out && Busy)) timeout("rtz_copy_reach");
        MR_n = 1'b0;
        @(negedge CLK);
        MR_n = 1'b1;
        exp_q.delete();
        emissions = 0;
        resp_hold = 1'b0;
        check("mr_send_out", {39'd0, Send_out}, 40'd0);
        check("mr_ack_out", {39'd0, Ack_out}, 40'd0);
        check("mr_busy", {39'd0, Busy}, 40'd0);
        check("mr_pkt_out", Pkt_out, 40'd0);
        check("mr_copy_idx", {39'd0, Copy_idx}, 40'd0);
`ifdef CX_PKT_CNT_EN
        check("mr_pkt_cnt", {24'd0, Pkt_cnt}, 40'd0);
`endif
        repeat (10) @(negedge CLK);
        check("mr_no_third", 40'(emissions), 40'd0);

        // Randomized traffic with random partner latency
        max_dly = 3;
        for (int i = 0; i < 40; i++) begin
            send_pkt({$urandom, $urandom}, 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end
        quiesce("rand_quiesce");
        check("scoreboard_empty", 40'(exp_q.size()), 40'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
